// File: rtl/control_jugada.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : control_jugada                                                  |
// | Brief    : Tic-tac-toe move-entry controller: button sync, move check,     |
// |            board/turn keeping, win/draw detection, 6-bit move word.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module control_jugada #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       botonJugar,
   input  logic [3:0] casillaSel,
   input  logic       nuevoJuego,
   output logic [5:0] registro1,
   output logic [8:0] tableroX,
   output logic [8:0] tableroO,
   output logic       turno,
   output logic [1:0] ganador,
   output logic       empate,
   output logic       jugadaInvalida,
   output logic [3:0] numJugadas
);

   typedef enum logic [2:0] {
      ESPERA  = 3'd0,
      VALIDA  = 3'd1,
      ESCRIBE = 3'd2,
      EVALUA  = 3'd3,
      FIN     = 3'd4
   } estado_t;

   localparam logic [3:0] c_max_casilla = 4'd8;
   localparam logic [3:0] c_total       = 4'd9;

   estado_t                r_estado;
   estado_t                w_siguiente;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_boton_prev;
   logic                   w_pulso;
   logic [3:0]             r_casilla;
   logic [8:0]             w_onehot;
   logic                   w_rechazo;
   logic [8:0]             w_mascara;
   logic                   w_gana;

   function automatic logic f_linea(input logic [8:0] m);
      return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
             (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
             (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync       <= '0;
         r_boton_prev <= 1'b0;
      end else begin
         r_sync       <= {r_sync[SYNC_STAGES-2:0], botonJugar};
         r_boton_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_pulso   = r_sync[SYNC_STAGES-1] & ~r_boton_prev;
   // Indices above 8 shift the bit out, so they never hit an occupied cell.
   assign w_onehot  = 9'd1 << r_casilla;
   assign w_rechazo = (r_casilla > c_max_casilla) | (|(w_onehot & (tableroX | tableroO)));
   assign w_mascara = turno ? tableroO : tableroX;
   assign w_gana    = f_linea(w_mascara);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_estado <= ESPERA;
      else        r_estado <= w_siguiente;
   end

   always_comb begin
      w_siguiente = r_estado;
      if (nuevoJuego) begin
         w_siguiente = ESPERA;
      end else begin
         case (r_estado)
            ESPERA:  if (w_pulso) w_siguiente = VALIDA;
            VALIDA:  w_siguiente = w_rechazo ? ESPERA : ESCRIBE;
            ESCRIBE: w_siguiente = EVALUA;
            EVALUA:  w_siguiente = (w_gana || numJugadas == c_total) ? FIN : ESPERA;
            FIN:     w_siguiente = FIN;
            default: w_siguiente = ESPERA;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_casilla      <= '0;
         registro1      <= '0;
         tableroX       <= '0;
         tableroO       <= '0;
         turno          <= 1'b0;
         ganador        <= 2'b00;
         empate         <= 1'b0;
         jugadaInvalida <= 1'b0;
         numJugadas     <= '0;
      end else begin
         jugadaInvalida <= 1'b0;
         if (nuevoJuego) begin
            registro1  <= '0;
            tableroX   <= '0;
            tableroO   <= '0;
            turno      <= 1'b0;
            ganador    <= 2'b00;
            empate     <= 1'b0;
            numJugadas <= '0;
         end else begin
            case (r_estado)
               ESPERA: if (w_pulso) r_casilla <= casillaSel;
               VALIDA: begin
                  if (w_rechazo) begin
                     jugadaInvalida <= 1'b1;
                     registro1      <= {turno, 1'b0, r_casilla};
                  end
               end
               ESCRIBE: begin
                  if (turno) tableroO <= tableroO | w_onehot;
                  else       tableroX <= tableroX | w_onehot;
                  registro1  <= {turno, 1'b1, r_casilla};
                  numJugadas <= numJugadas + 4'd1;
               end
               EVALUA: begin
                  // A winning 9th move reports the winner, not a draw.
                  if (w_gana)                    ganador <= {turno, ~turno};
                  else if (numJugadas == c_total) empate <= 1'b1;
                  else                           turno   <= ~turno;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_control_jugada.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_control_jugada                                               |
// | Brief    : Directed self-checking bench for control_jugada.                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_control_jugada;

   logic       clk;
   logic       rst_n;
   logic       botonJugar;
   logic [3:0] casillaSel;
   logic       nuevoJuego;
   logic [5:0] registro1;
   logic [8:0] tableroX;
   logic [8:0] tableroO;
   logic       turno;
   logic [1:0] ganador;
   logic       empate;
   logic       jugadaInvalida;
   logic [3:0] numJugadas;

   int checks   = 0;
   int failures = 0;
   int inv;

   control_jugada #(.SYNC_STAGES(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .botonJugar     (botonJugar),
      .casillaSel     (casillaSel),
      .nuevoJuego     (nuevoJuego),
      .registro1      (registro1),
      .tableroX       (tableroX),
      .tableroO       (tableroO),
      .turno          (turno),
      .ganador        (ganador),
      .empate         (empate),
      .jugadaInvalida (jugadaInvalida),
      .numJugadas     (numJugadas)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full press/release cycle; counts cycles with jugadaInvalida high.
   task automatic press(input logic [3:0] c, output int n_inv);
      n_inv      = 0;
      casillaSel = c;
      botonJugar = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (jugadaInvalida) n_inv++;
      end
      botonJugar = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (jugadaInvalida) n_inv++;
      end
   endtask

   task automatic new_game();
      @(negedge clk);
      nuevoJuego = 1'b1;
      @(negedge clk);
      nuevoJuego = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_reg"},  9'(registro1),      9'h000);
      chk({tag, "_X"},    tableroX,           9'h000);
      chk({tag, "_O"},    tableroO,           9'h000);
      chk({tag, "_turn"}, 9'(turno),          9'h000);
      chk({tag, "_gan"},  9'(ganador),        9'h000);
      chk({tag, "_emp"},  9'(empate),         9'h000);
      chk({tag, "_inv"},  9'(jugadaInvalida), 9'h000);
      chk({tag, "_num"},  9'(numJugadas),     9'h000);
   endtask

   // Press while a pulso is pending, and raise nuevoJuego in the pulso cycle.
   task automatic press_with_restart(input logic [3:0] c);
      @(negedge clk);
      casillaSel = c;
      botonJugar = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      nuevoJuego = 1'b1;
      @(negedge clk);
      nuevoJuego = 1'b0;
      botonJugar = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      rst_n      = 1'b0;
      botonJugar = 1'b0;
      casillaSel = 4'd0;
      nuevoJuego = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // X wins on the top row
      press(4'd0, inv); press(4'd3, inv); press(4'd1, inv); press(4'd4, inv); press(4'd2, inv);
      chk("xwin_gan",  9'(ganador),    9'h001);
      chk("xwin_num",  9'(numJugadas), 9'h005);
      chk("xwin_reg",  9'(registro1),  9'h012);
      chk("xwin_X",    tableroX,       9'h007);
      chk("xwin_O",    tableroO,       9'h018);
      chk("xwin_turn", 9'(turno),      9'h000);
      chk("xwin_emp",  9'(empate),     9'h000);

      // FIN ignores the button
      press(4'd5, inv);
      chk("fin_num", 9'(numJugadas), 9'h005);
      chk("fin_O",   tableroO,       9'h018);
      chk("fin_reg", 9'(registro1),  9'h012);
      chk("fin_inv", 9'(inv),        9'h000);

      press_with_restart(4'd6);
      chk_all_zero("restart_fin");
      press_with_restart(4'd7);
      chk("restart_esp_num", 9'(numJugadas), 9'h000);
      chk("restart_esp_X",   tableroX,       9'h000);

      // Illegal index
      press(4'd12, inv);
      chk("illegal_inv",  9'(inv),        9'h001);
      chk("illegal_reg",  9'(registro1),  9'h00C);
      chk("illegal_X",    tableroX,       9'h000);
      chk("illegal_O",    tableroO,       9'h000);
      chk("illegal_num",  9'(numJugadas), 9'h000);
      chk("illegal_turn", 9'(turno),      9'h000);

      // Occupied cell
      press(4'd4, inv);
      chk("occ1_X",    tableroX,       9'h010);
      chk("occ1_turn", 9'(turno),      9'h001);
      chk("occ1_inv",  9'(inv),        9'h000);
      press(4'd4, inv);
      chk("occ2_inv",  9'(inv),        9'h001);
      chk("occ2_reg",  9'(registro1),  9'h024);
      chk("occ2_num",  9'(numJugadas), 9'h001);
      chk("occ2_turn", 9'(turno),      9'h001);
      chk("occ2_O",    tableroO,       9'h000);

      // Draw
      new_game();
      press(4'd0, inv); press(4'd1, inv); press(4'd2, inv);
      press(4'd4, inv); press(4'd3, inv); press(4'd5, inv);
      press(4'd7, inv); press(4'd6, inv); press(4'd8, inv);
      chk("draw_emp",  9'(empate),     9'h001);
      chk("draw_gan",  9'(ganador),    9'h000);
      chk("draw_num",  9'(numJugadas), 9'h009);
      chk("draw_reg",  9'(registro1),  9'h018);
      chk("draw_X",    tableroX,       9'h18D);
      chk("draw_O",    tableroO,       9'h072);
      chk("draw_turn", 9'(turno),      9'h000);

      // Reset while in ESCRIBE
      new_game();
      press(4'd0, inv); press(4'd3, inv);
      @(negedge clk);
      casillaSel = 4'd5;
      botonJugar = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("rstmid");
      botonJugar = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      press(4'd5, inv);
      chk("after_X",    tableroX,       9'h020);
      chk("after_O",    tableroO,       9'h000);
      chk("after_num",  9'(numJugadas), 9'h001);
      chk("after_reg",  9'(registro1),  9'h015);
      chk("after_turn", 9'(turno),      9'h001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/control_jugada.md
# control_jugada

Move-entry controller for the tic-tac-toe datapath, sitting directly upstream of the 6-bit move register. It converts a push-button press plus a selected cell index into a validated move and keeps the 3x3 board, the turn and the move count. It checks each move for a win or draw and presents the resulting 6-bit move word to the register stage.

## Interface

- SYNC_STAGES, 2: flip-flop depth of the botonJugar synchronizer (legal values 2 or more).

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- botonJugar  in  1  raw, asynchronous push-button level; a rising edge requests a move.
- casillaSel  in  4  selected cell, row-major 0..8; values 9..15 are illegal.
- nuevoJuego  in  1  synchronous level, clk domain; restarts the game.
- registro1  out  6  move word {jugador, valido, casilla[3:0]} that feeds the move register.
- tableroX  out  9  occupancy mask for X; bit i is cell i.
- tableroO  out  9  occupancy mask for O.
- turno  out  1  player to move: 0 = X, 1 = O.
- ganador  out  2  00 = none, 01 = X, 10 = O; 11 never occurs.
- empate  out  1  draw flag.
- jugadaInvalida  out  1  one-cycle pulse when a move is rejected.
- numJugadas  out  4  accepted moves, 0..9.

## Operation

- **Reset:** every output is 0 and the FSM is in ESPERA.
- **Button input:**
  - botonJugar passes through SYNC_STAGES flops, then a rising-edge detector produces a one-cycle pulso.
  - A pulso that arrives in any state other than ESPERA is dropped, not queued.
- **ESPERA:** on pulso, latch casillaSel into casillaReg and go to VALIDA.
- **VALIDA:**
  - A move is rejected if casillaReg > 8, or if the bit for that cell is set in tableroX or tableroO.
  - Rejected: pulse jugadaInvalida, load registro1 with {turno, 0, casillaReg}, return to ESPERA.
  - Accepted: go to ESCRIBE.
- **ESCRIBE:**
  - Set bit casillaReg in the current player's mask.
  - Load registro1 with {turno, 1, casillaReg}.
  - Increment numJugadas.
  - Go to EVALUA.
- **EVALUA:** test the current player's mask (which already includes the new move) against the 8 winning lines: {0,1,2}, {3,4,5}, {6,7,8}, {0,3,6}, {1,4,7}, {2,5,8}, {0,4,8}, {2,4,6}.
  - Win: ganador = turno+1, go to FIN; turno does not toggle.
  - Else if numJugadas == 9: set empate, go to FIN; turno does not toggle.
  - Else: toggle turno, go to ESPERA.
  - A win on the 9th move reports ganador only; empate stays 0.
- **FIN:** ignore the button and hold all outputs until nuevoJuego.
- **registro1:** holds its last value between updates.
- **nuevoJuego:**
  - Sampled high in any state, on the next edge it clears the masks, numJugadas, ganador, empate, turno and registro1, and moves the FSM to ESPERA.
  - It has priority over a simultaneous pulso; that pulso is discarded.
- **rst_n mid-operation:** aborts any state immediately (asynchronously); no partial board update survives.

## Timing

- **Button to pulso:** a botonJugar rise produces pulso SYNC_STAGES+1 edges later at most.
- **Move sequence** (edge N samples pulso in ESPERA):
  - Edge N: go to VALIDA.
  - Edge N+1, rejected move: jugadaInvalida and registro1 valid for one cycle; FSM back in ESPERA.
  - Edge N+1, accepted move: go to ESCRIBE.
  - Edge N+2: mask bit, registro1 and numJugadas updated.
  - Edge N+3: ganador, empate and turno updated.
- **Throughput:** a new move is accepted at the earliest 4 edges after the previous pulso; the button must be released and pressed again.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan

- **X wins:**
  - Stimulus: reset, then press cells 0, 3, 1, 4, 2.
  - Required: ganador = 01, numJugadas = 5, registro1 = 6'h12, tableroX = 9'h007, tableroO = 9'h018, turno = 0, FSM in FIN.
- **Occupied cell:**
  - Stimulus: press cell 4, then press cell 4 again.
  - Required: jugadaInvalida is a single-cycle pulse, registro1 = 6'h24, numJugadas stays 1, turno stays 1.
- **Illegal index:**
  - Stimulus: casillaSel = 12 and press.
  - Required: jugadaInvalida pulses, registro1 = 6'h0C, board unchanged.
- **Draw:**
  - Stimulus: press cells 0, 1, 2, 4, 3, 5, 7, 6, 8.
  - Required: empate = 1, ganador = 00, numJugadas = 9, registro1 = 6'h18.
- **FIN and restart:**
  - Stimulus: in FIN, press the button, then assert nuevoJuego in the same cycle as a pulso.
  - Required: the press is ignored, then every output returns to 0 in ESPERA with no move recorded.
- **Reset mid-move:**
  - Stimulus: assert rst_n low while the FSM is in ESCRIBE.
  - Required: all outputs are 0 immediately, and the first move after release is accepted as move 1 by X.
